// File: rtl/data_mem_unit.sv
// data_mem_unit: wait-state data memory stage for the 16-bit RISC datapath.
// Accepts one load or store at a time from execute. The core is held in stall
// for WAIT_STATES extra cycles, then a one-cycle Mem_ready pulse completes
// the access.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-low reset
//   Mem_read   - load request (level, held until Mem_ready)
//   Mem_write  - store request (level, held until Mem_ready; wins over Mem_read)
//   Addr       - word address, captured on accept
//   Data_write - store data, captured on accept
//   Data_out   - registered load data, held until the next completed load
//   Mem_ready  - one-cycle completion pulse
//   Stall      - combinational pipeline hold
//   Addr_err   - pulses with Mem_ready when the address is >= DEPTH
module data_mem_unit #(
    parameter int unsigned N           = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Mem_read,
    input  logic              Mem_write,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [N-1:0]      Data_write,
    output logic [N-1:0]      Data_out,
    output logic              Mem_ready,
    output logic              Stall,
    output logic              Addr_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;
    logic              enter_done;

    logic [ADDR_W-1:0] addr_q;
    logic [N-1:0]      wdata_q;
    logic              op_write_q;

    logic              req;
    logic [ADDR_W-1:0] eff_addr;
    logic [N-1:0]      eff_data;
    logic              eff_write;
    logic              in_range;
    logic [IDX_W-1:0]  eff_idx;

    logic [N-1:0]      mem [DEPTH];

    // With zero wait states the access completes straight out of IDLE, so the
    // commit must see the live request rather than the captured copy.
    always_comb begin
        req       = Mem_read | Mem_write;
        eff_addr  = (state == IDLE) ? Addr       : addr_q;
        eff_data  = (state == IDLE) ? Data_write : wdata_q;
        eff_write = (state == IDLE) ? Mem_write  : op_write_q;
        in_range  = (eff_addr < ADDR_W'(DEPTH));
        eff_idx   = eff_addr[IDX_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_W'(WAIT_STATES);
                    state_nxt = (WAIT_STATES == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                // Counter reaching zero on this edge ends the wait
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        enter_done = (state_nxt == DONE);
        Stall      = ((state == IDLE) && req) || (state == BUSY);
    end

    // Request capture and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            Data_out   <= '0;
            Mem_ready  <= 1'b0;
            Addr_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= Addr;
                wdata_q    <= Data_write;
                op_write_q <= Mem_write;
            end
            Mem_ready <= enter_done;
            Addr_err  <= enter_done & ~in_range;
            // Stores never disturb Data_out; out-of-range loads return zero
            if (enter_done && !eff_write) begin
                Data_out <= in_range ? mem[eff_idx] : '0;
            end
        end
    end

    // Storage array, intentionally left uninitialised by reset
    always_ff @(posedge clk) begin
        if (rst && enter_done && eff_write && in_range) begin
            mem[eff_idx] <= eff_data;
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_data;
        bit          chk_data;
        bit          exp_err;
    } op_t;

    typedef struct {
        logic [15:0] data;
        bit          chk_data;
        bit          err;
        int          lat;
    } exp_t;

    logic clk;
    int   checks;
    int   failures;
    exp_t sb[$];

    // Instance with two wait states
    logic        rst2, rd2, wr2;
    logic [15:0] a2, d2, dout2;
    logic        rdy2, stall2, err2;

    // Instance with zero wait states
    logic        rst0, rd0, wr0;
    logic [15:0] a0, d0, dout0;
    logic        rdy0, stall0, err0;

    data_mem_unit #(.N(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst2), .Mem_read(rd2), .Mem_write(wr2), .Addr(a2),
        .Data_write(d2), .Data_out(dout2), .Mem_ready(rdy2), .Stall(stall2),
        .Addr_err(err2)
    );

    data_mem_unit #(.N(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst0), .Mem_read(rd0), .Mem_write(wr0), .Addr(a0),
        .Data_write(d0), .Data_out(dout0), .Mem_ready(rdy0), .Stall(stall0),
        .Addr_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request on the selected instance (sel=1: two wait states)
    // and reports what the DUT did; it makes no judgement itself.
    task automatic drive_op(input bit sel, input bit rd, input bit wr,
                            input logic [15:0] a, input logic [15:0] d,
                            output int lat, output int stalls,
                            output logic [15:0] dout, output logic err,
                            output bit timeout);
        @(negedge clk);
        if (sel) begin rd2 = rd; wr2 = wr; a2 = a; d2 = d; end
        else     begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
        lat = -1; stalls = 0; dout = 'x; err = 1'bx; timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (sel ? stall2 : stall0) stalls++;
            if (sel ? rdy2 : rdy0) begin
                lat = c;
                dout = sel ? dout2 : dout0;
                err = sel ? err2 : err0;
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (sel) begin rd2 = 1'b0; wr2 = 1'b0; end
        else     begin rd0 = 1'b0; wr0 = 1'b0; end
    endtask

    task automatic test_reset();
        rst2 = 1'b0; rst0 = 1'b0;
        rd2 = 1'b0; wr2 = 1'b0; a2 = '0; d2 = '0;
        rd0 = 1'b0; wr0 = 1'b0; a0 = '0; d0 = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dout2 !== 16'h0000) begin failures++; $display("FAIL reset_dout_ws2 got=%h exp=0000", dout2); end
        checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL reset_ready_ws2 got=%b exp=0", rdy2); end
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err_ws2 got=%b exp=0", err2); end
        checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL reset_stall_ws2 got=%b exp=0", stall2); end
        checks++; if (dout0 !== 16'h0000) begin failures++; $display("FAIL reset_dout_ws0 got=%h exp=0000", dout0); end
        checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_ready_ws0 got=%b exp=0", rdy0); end
        rst2 = 1'b1; rst0 = 1'b1;
        @(negedge clk); #1;
        checks++; if (rdy2 !== 1'b0 || stall2 !== 1'b0) begin failures++; $display("FAIL idle_after_reset got rdy=%b stall=%b exp 0 0", rdy2, stall2); end
    endtask

    task automatic test_store_load();
        op_t ops[$];
        int lat, stl; logic [15:0] dout; logic err; bit to; exp_t e;
        ops.push_back(op_t'{0, 1, 16'h0010, 16'hBEEF, 16'h0000, 1, 0});
        ops.push_back(op_t'{1, 0, 16'h0010, 16'h0000, 16'hBEEF, 1, 0});
        foreach (ops[i]) begin
            sb.push_back(exp_t'{ops[i].exp_data, ops[i].chk_data, ops[i].exp_err, 3});
            drive_op(1, ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, lat, stl, dout, err, to);
            e = sb.pop_front();
            checks++; if (to || lat !== e.lat) begin failures++; $display("FAIL sl_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (stl !== e.lat) begin failures++; $display("FAIL sl_stall[%0d] got=%0d exp=%0d", i, stl, e.lat); end
            checks++; if (err !== e.err) begin failures++; $display("FAIL sl_err[%0d] got=%b exp=%b", i, err, e.err); end
            if (e.chk_data) begin
                checks++; if (dout !== e.data) begin failures++; $display("FAIL sl_data[%0d] got=%h exp=%h", i, dout, e.data); end
            end
        end
        // Mem_ready must be a single-cycle pulse and data must hold
        @(negedge clk); #1;
        checks++; if (rdy2 !== 1'b0 || stall2 !== 1'b0) begin failures++; $display("FAIL ready_pulse got rdy=%b stall=%b exp 0 0", rdy2, stall2); end
        checks++; if (dout2 !== 16'hBEEF) begin failures++; $display("FAIL data_hold got=%h exp=beef", dout2); end
    endtask

    task automatic test_wait0();
        op_t ops[$];
        int lat, stl; logic [15:0] dout; logic err; bit to; exp_t e;
        ops.push_back(op_t'{1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 0});
        ops.push_back(op_t'{0, 1, 16'h0000, 16'h1234, 16'h0000, 0, 0});
        ops.push_back(op_t'{1, 0, 16'h0000, 16'h0000, 16'h1234, 1, 0});
        ops.push_back(op_t'{0, 1, 16'h00FF, 16'h0F0F, 16'h1234, 1, 0});
        ops.push_back(op_t'{1, 0, 16'h00FF, 16'h0000, 16'h0F0F, 1, 0});
        foreach (ops[i]) begin
            sb.push_back(exp_t'{ops[i].exp_data, ops[i].chk_data, ops[i].exp_err, 1});
            drive_op(0, ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, lat, stl, dout, err, to);
            e = sb.pop_front();
            checks++; if (to || lat !== e.lat) begin failures++; $display("FAIL w0_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (stl !== e.lat) begin failures++; $display("FAIL w0_stall[%0d] got=%0d exp=%0d", i, stl, e.lat); end
            checks++; if (err !== e.err) begin failures++; $display("FAIL w0_err[%0d] got=%b exp=%b", i, err, e.err); end
            if (e.chk_data) begin
                checks++; if (dout !== e.data) begin failures++; $display("FAIL w0_data[%0d] got=%h exp=%h", i, dout, e.data); end
            end
        end
    endtask

    task automatic test_out_of_range();
        op_t ops[$];
        int lat, stl; logic [15:0] dout; logic err; bit to; exp_t e;
        // 0x0100 aliases index 0 in its low bits; the store must not land there
        ops.push_back(op_t'{0, 1, 16'h0000, 16'h7777, 16'hBEEF, 1, 0});
        ops.push_back(op_t'{0, 1, 16'h0100, 16'hAAAA, 16'h0000, 0, 1});
        ops.push_back(op_t'{1, 0, 16'h0100, 16'h0000, 16'h0000, 1, 1});
        ops.push_back(op_t'{1, 0, 16'h0000, 16'h0000, 16'h7777, 1, 0});
        ops.push_back(op_t'{1, 0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1});
        ops.push_back(op_t'{1, 0, 16'h00FF, 16'h0000, 16'h0000, 0, 0});
        foreach (ops[i]) begin
            sb.push_back(exp_t'{ops[i].exp_data, ops[i].chk_data, ops[i].exp_err, 3});
            drive_op(1, ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, lat, stl, dout, err, to);
            e = sb.pop_front();
            checks++; if (to || lat !== e.lat) begin failures++; $display("FAIL oor_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (err !== e.err) begin failures++; $display("FAIL oor_err[%0d] got=%b exp=%b", i, err, e.err); end
            if (e.chk_data) begin
                checks++; if (dout !== e.data) begin failures++; $display("FAIL oor_data[%0d] got=%h exp=%h", i, dout, e.data); end
            end
        end
    endtask

    task automatic test_simultaneous();
        op_t ops[$];
        int lat, stl; logic [15:0] dout; logic err; bit to; exp_t e;
        ops.push_back(op_t'{1, 1, 16'h0020, 16'h5A5A, 16'h0000, 1, 0});
        ops.push_back(op_t'{1, 0, 16'h0020, 16'h0000, 16'h5A5A, 1, 0});
        foreach (ops[i]) begin
            sb.push_back(exp_t'{ops[i].exp_data, ops[i].chk_data, ops[i].exp_err, 3});
            drive_op(1, ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, lat, stl, dout, err, to);
            e = sb.pop_front();
            checks++; if (to || lat !== e.lat) begin failures++; $display("FAIL sim_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            if (e.chk_data) begin
                checks++; if (dout !== e.data) begin failures++; $display("FAIL sim_data[%0d] got=%h exp=%h", i, dout, e.data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        int lat, stl; logic [15:0] dout; logic err; bit to; exp_t e;
        logic [15:0] mid_addr;
        ops.push_back(op_t'{0, 1, 16'h0044, 16'hC3C3, 16'h5A5A, 1, 0});
        ops.push_back(op_t'{1, 0, 16'h0044, 16'h0000, 16'hC3C3, 1, 0});
        ops.push_back(op_t'{0, 1, 16'h0044, 16'h3C3C, 16'hC3C3, 1, 0});
        ops.push_back(op_t'{1, 0, 16'h0044, 16'h0000, 16'h3C3C, 1, 0});
        foreach (ops[i]) begin
            sb.push_back(exp_t'{ops[i].exp_data, ops[i].chk_data, ops[i].exp_err, 3});
            drive_op(1, ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, lat, stl, dout, err, to);
            e = sb.pop_front();
            checks++; if (to || lat !== e.lat) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (dout !== e.data) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, dout, e.data); end
        end
        // Address changes after accept must be ignored
        sb.push_back(exp_t'{16'h3C3C, 1, 0, 3});
        @(negedge clk);
        rd2 = 1'b1; a2 = 16'h0044;
        @(negedge clk);
        mid_addr = 16'h0100;
        a2 = mid_addr;
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            #1;
            if (rdy2) begin lat = c; dout = dout2; err = err2; break; end
            @(negedge clk);
        end
        rd2 = 1'b0; a2 = '0;
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL late_addr_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (dout !== e.data || err !== e.err) begin failures++; $display("FAIL late_addr_data got=%h/%b exp=%h/%b", dout, err, e.data, e.err); end
    endtask

    task automatic test_reset_mid();
        int lat, stl; logic [15:0] dout; logic err; bit to; exp_t e;
        bit seen;
        drive_op(1, 0, 1, 16'h0030, 16'h0001, lat, stl, dout, err, to);
        checks++; if (to || lat !== 3) begin failures++; $display("FAIL rm_prestore_latency got=%0d exp=3", lat); end
        @(negedge clk);
        wr2 = 1'b1; a2 = 16'h0030; d2 = 16'hFFFF;
        @(negedge clk); #1;
        checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL rm_busy_stall got=%b exp=1", stall2); end
        rst2 = 1'b0; wr2 = 1'b0;
        @(negedge clk); #1;
        rst2 = 1'b1;
        #1;
        checks++; if (stall2 !== 1'b0 || rdy2 !== 1'b0) begin failures++; $display("FAIL rm_idle got stall=%b rdy=%b exp 0 0", stall2, rdy2); end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (rdy2) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rm_no_ready got=%b exp=0", seen); end
        sb.push_back(exp_t'{16'h0001, 1, 0, 3});
        drive_op(1, 1, 0, 16'h0030, 16'h0000, lat, stl, dout, err, to);
        e = sb.pop_front();
        checks++; if (to || lat !== e.lat) begin failures++; $display("FAIL rm_load_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (dout !== e.data) begin failures++; $display("FAIL rm_load_data got=%h exp=%h", dout, e.data); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_store_load();
        test_wait0();
        test_out_of_range();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test sequence");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Wait-state data-memory stage of the 16-bit RISC datapath. It takes load/store requests from the execute stage, holds the core in stall for a programmable number of wait states, and returns the loaded word on Data_out. Data_out is the memory-read input of the write-back select multiplexer, which chooses between sign-extended immediate, memory read data and store data for register write-back.

## Interface
- N, 16, data word width
- ADDR_W, 16, address width
- DEPTH, 256, number of N-bit words implemented (addresses 0..DEPTH-1)
- WAIT_STATES, 2, extra cycles per access (0..15)

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- Mem_read  in  1  load request, level, held until Mem_ready
- Mem_write  in  1  store request, level, held until Mem_ready
- Addr  in  ADDR_W  word address
- Data_write  in  N  store data
- Data_out  out  N  load data, registered, held until next completed load
- Mem_ready  out  1  one-cycle completion pulse
- Stall  out  1  core must hold its pipeline while high
- Addr_err  out  1  one-cycle pulse coincident with Mem_ready when Addr >= DEPTH

## Operation
- States: IDLE, BUSY, DONE. The wait counter is 4 bits.
- IDLE:
  - Mem_write or Mem_read high: capture Addr, Data_write and op (write has priority; both high = store only), and load counter with WAIT_STATES.
  - Next state is BUSY, or DONE directly when WAIT_STATES = 0.
- BUSY: decrement counter. When the counter reaches 0, the next state is DONE.
- Entering DONE (same edge):
  - Store with in-range address: mem[addr] <= data.
  - Load with in-range address: Data_out <= mem[addr].
  - Out-of-range address: no memory write, Data_out <= 0, Addr_err = 1 for the DONE cycle.
- DONE: Mem_ready = 1 for exactly one cycle, then IDLE unconditionally. A request still high in DONE is not re-accepted.
- Stall (combinational) = (IDLE and (Mem_read or Mem_write)) or BUSY. Stall is low in DONE.
- A store leaves Data_out unchanged.
- Memory array is not cleared by reset.

## Timing
- Request first seen high in IDLE at cycle T:
  - Stall high on cycles T..T+WAIT_STATES.
  - Mem_ready and Addr_err valid at T+WAIT_STATES+1.
  - Load data valid on Data_out from T+WAIT_STATES+1.
- Request-to-ready latency is WAIT_STATES+1 cycles. Back-to-back accesses are accepted every WAIT_STATES+2 cycles.
- Read-after-write to the same address returns the new data with no hazard, because the write commits on DONE entry.
- Changes to Addr or Data_write after the accept cycle are ignored.
- Reset values (rst low at an edge):
  - State IDLE, counter 0.
  - Data_out = 0, Mem_ready = 0, Addr_err = 0.
  - Stall follows its combinational equation.
- Reset mid-operation (BUSY) aborts the access. A pending store is not written and no Mem_ready is issued.
- Reset has priority over all other activity in the same cycle.

## Test plan
- Reset, WAIT_STATES=2: rst low 2 cycles -> Data_out=16'h0000, Mem_ready=0, Addr_err=0, Stall=0 with no request.
- Store then load:
  - Store 16'hBEEF to 8'h10 -> Stall high 3 cycles, Mem_ready pulse on the 4th cycle, Data_out still 0.
  - Load from 8'h10 -> Data_out=16'hBEEF with the Mem_ready pulse 3 cycles after the request.
- WAIT_STATES=0:
  - Load -> Stall high 1 cycle, Mem_ready the next cycle.
  - Back-to-back store/load to 8'h00 with 16'h1234 -> load returns 16'h1234.
- Out-of-range:
  - Store 16'hAAAA to address 16'h0100 (DEPTH=256) -> Addr_err and Mem_ready pulse together, no memory modification.
  - Subsequent load of 16'h0100 -> Data_out=0 with Addr_err.
  - Subsequent load of 16'h0000 -> previous contents.
- Simultaneous Mem_read and Mem_write, Addr 8'h20, Data_write 16'h5A5A -> treated as store. Data_out unchanged; a later load of 8'h20 returns 16'h5A5A.
- Reset mid-store:
  - Store 16'hFFFF to 8'h30 (prior contents 16'h0001), rst low during BUSY -> no Mem_ready, state IDLE.
  - Later load of 8'h30 returns 16'h0001.
